rlc_drive_clock_gen: RTL and testbench

Programmable square-wave drive generator for the RLC game datapath. It consumes the 1-bit output-clock-enable level written by software through the OutputClockEnable PIO and produces the gated drive clock that excites the RLC network, plus a one-cycle sample strobe per rising drive edge. Half-period and burst length are set over a small Avalon-MM slave on the same bus as the PIO.

---
 rtl/rlc_game_pkg.sv | 19 +
 rtl/rlc_sync2.sv | 28 ++
 rtl/rlc_drive_clock_gen.sv | 151 +++++++++++++++
 tb/tb_rlc_drive_clock_gen.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlc_game_pkg.sv
// Shared types and register map for the RLC game datapath.
package rlc_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_HALF   = 2'd0;
    localparam logic [1:0] ADDR_BURST  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int STAT_RUNNING_BIT = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_CYCLES_LSB  = 16;

endpackage

// File: rtl/rlc_sync2.sv
// Generic two-flop synchronizer for asynchronous control levels (e.g. PIO outputs).
module rlc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                meta_reg[gi] <= 1'b0;
                sync_reg[gi] <= 1'b0;
            end else begin
                meta_reg[gi] <= d[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/rlc_drive_clock_gen.sv
// Gated square-wave drive generator for the RLC network with burst control,
// sample strobe and a small Avalon-MM register file.
module rlc_drive_clock_gen
    import rlc_game_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_enable_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        drive_out,
    output logic        sample_strobe,
    output logic        running
);

    logic             en_s;
    state_t           state_reg;
    logic [CNT_W-1:0] half_period_reg;
    logic [CNT_W-1:0] burst_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cycles_done_reg;
    logic             done_reg;
    logic             drive_reg;
    logic             strobe_reg;
    logic             running_reg;

    logic             write_en;
    logic             clear_done;
    logic [CNT_W-1:0] reload_cnt;
    logic [CNT_W:0]   cycles_plus1;
    logic [CNT_W-1:0] cycles_sat;
    logic             burst_hit;
    logic             unused_wdata;

    rlc_sync2 #(.WIDTH(1)) u_en_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (clk_enable_in),
        .q       (en_s)
    );

    assign write_en   = chipselect && !write_n;
    assign clear_done = write_en && (address == ADDR_STATUS) && writedata[STAT_DONE_BIT];

    // A zero half-period at reload behaves as one cycle per phase.
    assign reload_cnt   = (half_period_reg == '0) ? '0 : half_period_reg - 1'b1;
    assign cycles_plus1 = {1'b0, cycles_done_reg} + 1'b1;
    assign cycles_sat   = (&cycles_done_reg) ? cycles_done_reg : cycles_plus1[CNT_W-1:0];
    assign burst_hit    = (burst_reg != '0) && (cycles_plus1 == {1'b0, burst_reg});
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_period_reg <= CNT_W'(DEFAULT_HALF);
            burst_reg       <= '0;
        end else if (write_en) begin
            case (address)
                ADDR_HALF:  half_period_reg <= writedata[CNT_W-1:0];
                ADDR_BURST: burst_reg       <= writedata[CNT_W-1:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            cycles_done_reg <= '0;
            done_reg        <= 1'b0;
            drive_reg       <= 1'b0;
            strobe_reg      <= 1'b0;
            running_reg     <= 1'b0;
        end else begin
            // Drive follows the state by one cycle; the strobe marks its first high cycle.
            drive_reg  <= (state_reg == ST_HIGH);
            strobe_reg <= (state_reg == ST_HIGH) && !drive_reg;
            if (clear_done) begin
                done_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (en_s && (half_period_reg != '0)) begin
                        state_reg       <= ST_HIGH;
                        cnt_reg         <= reload_cnt;
                        cycles_done_reg <= '0;
                        done_reg        <= 1'b0;
                        running_reg     <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_LOW;
                        cnt_reg   <= reload_cnt;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_reg == '0) begin
                        cycles_done_reg <= cycles_sat;
                        if (!en_s) begin
                            state_reg   <= ST_IDLE;
                            running_reg <= 1'b0;
                        end else if (burst_hit) begin
                            state_reg   <= ST_DONE;
                            done_reg    <= 1'b1;
                            running_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_HIGH;
                            cnt_reg   <= reload_cnt;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!en_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_HALF:  readdata[CNT_W-1:0] = half_period_reg;
            ADDR_BURST: readdata[CNT_W-1:0] = burst_reg;
            ADDR_STATUS: begin
                readdata[STAT_RUNNING_BIT]              = running_reg;
                readdata[STAT_DONE_BIT]                 = done_reg;
                readdata[STAT_CYCLES_LSB +: CNT_W]      = cycles_done_reg;
            end
            default: readdata = '0;
        endcase
    end

    assign drive_out     = drive_reg;
    assign sample_strobe = strobe_reg;
    assign running       = running_reg;

endmodule

// File: tb/tb_rlc_drive_clock_gen.sv
// Self-checking bench for rlc_drive_clock_gen: directed scenarios plus randomized
// enable patterns checked against a period-level reference model.
module tb_rlc_drive_clock_gen;
    import rlc_game_pkg::*;

    localparam int MAXE = 512;

    logic        clk;
    logic        reset_n;
    logic        clk_enable_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        drive_out;
    logic        sample_strobe;
    logic        running;

    int checks;
    int errors;

    // en_lvl[e] is the enable level held just before clock edge e of a scenario.
    bit en_lvl  [MAXE];
    bit exp_drv [MAXE];
    bit exp_stb [MAXE];
    bit exp_run [MAXE];
    bit act_drv [MAXE];
    bit act_stb [MAXE];
    int model_cycles;
    bit model_done;

    rlc_drive_clock_gen #(.CNT_W(16), .DEFAULT_HALF(25)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_enable_in (clk_enable_in),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .drive_out     (drive_out),
        .sample_strobe (sample_strobe),
        .running       (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("WR addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
        $display("RD addr=%0d data=0x%08h", a, d);
    endtask

    // Period-level model: a run starts when the synchronized enable (two edges
    // late) is seen in idle; each period is h high + h low; at the end of a
    // period the run stops, finishes the burst, or starts the next period.
    function automatic void build_model(input int h, input int b, input int n_e);
        int mode;
        int s;
        bit en_s;
        mode = 0;
        s = 0;
        for (int e = 0; e < MAXE; e++) begin
            exp_drv[e] = 1'b0;
            exp_stb[e] = 1'b0;
            exp_run[e] = 1'b0;
        end
        model_cycles = 0;
        model_done = 1'b0;
        for (int e = 0; e < n_e; e++) begin
            en_s = (e >= 2) ? en_lvl[e-2] : 1'b0;
            case (mode)
                0: if (en_s) begin
                    mode = 1;
                    s = e;
                    model_cycles = 0;
                    model_done = 1'b0;
                end
                1: if (e == s + 2*h) begin
                    model_cycles++;
                    if (!en_s) mode = 0;
                    else if (b != 0 && model_cycles == b) begin
                        mode = 2;
                        model_done = 1'b1;
                    end else s = e;
                end
                default: if (!en_s) mode = 0;
            endcase
            exp_run[e] = (mode == 1);
            if (e + 1 < MAXE) begin
                exp_drv[e+1] = (mode == 1) && (e < s + h);
                exp_stb[e+1] = (mode == 1) && (e == s);
            end
        end
    endfunction

    task automatic run_scenario(input string name, input int h, input int b, input int n_e);
        logic [31:0] rd;
        bus_write(ADDR_HALF, 32'(h));
        bus_write(ADDR_BURST, 32'(b));
        build_model(h, b, n_e);
        for (int e = 0; e < n_e; e++) begin
            clk_enable_in = en_lvl[e];
            @(posedge clk);
            @(negedge clk);
            act_drv[e] = drive_out;
            act_stb[e] = sample_strobe;
            checks++;
            if (drive_out !== exp_drv[e]) begin
                errors++;
                $display("FAIL %s drive_out edge %0d: got %b expected %b", name, e, drive_out, exp_drv[e]);
            end
            checks++;
            if (sample_strobe !== exp_stb[e]) begin
                errors++;
                $display("FAIL %s sample_strobe edge %0d: got %b expected %b", name, e, sample_strobe, exp_stb[e]);
            end
            checks++;
            if (running !== exp_run[e]) begin
                errors++;
                $display("FAIL %s running edge %0d: got %b expected %b", name, e, running, exp_run[e]);
            end
        end
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd[1] !== model_done) begin
            errors++;
            $display("FAIL %s status.done: got %b expected %b", name, rd[1], model_done);
        end
        checks++;
        if (rd[31:16] !== model_cycles[15:0]) begin
            errors++;
            $display("FAIL %s status.cycles_done: got %0d expected %0d", name, rd[31:16], model_cycles);
        end
        $display("SCENARIO %s half=%0d burst=%0d edges=%0d cycles_done=%0d done=%0d",
                 name, h, b, n_e, model_cycles, model_done);
    endtask

    task automatic count_run(input bit lvl, output int len);
        len = 0;
        while (drive_out === lvl && len < 64) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (drive_out !== 1'b0 || running !== 1'b0 || sample_strobe !== 1'b0) begin
                errors++;
                $display("FAIL reset outputs: got drive=%b run=%b strobe=%b expected 0/0/0",
                         drive_out, running, sample_strobe);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(ADDR_HALF, rd);
        checks++;
        if (rd !== 32'd25) begin errors++; $display("FAIL reset half_period: got %0d expected 25", rd); end
        bus_read(ADDR_BURST, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset burst: got %0d expected 0", rd); end
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset status: got 0x%08h expected 0", rd); end
    endtask

    task automatic test_addr3();
        logic [31:0] rd;
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL addr3 read: got 0x%08h expected 0", rd); end
        bus_read(ADDR_HALF, rd);
        checks++;
        if (rd !== 32'd25) begin errors++; $display("FAIL addr3 write side effect: half got %0d expected 25", rd); end
    endtask

    task automatic test_continuous();
        int rises;
        int first_hi;
        int last_hi;
        for (int e = 0; e < MAXE; e++) en_lvl[e] = (e <= 12);
        run_scenario("continuous", 3, 0, 30);
        rises = 0;
        first_hi = -1;
        last_hi = -1;
        for (int e = 0; e < 30; e++) begin
            if (act_stb[e]) rises++;
            if (act_drv[e] && first_hi < 0) first_hi = e;
            if (act_drv[e]) last_hi = e;
        end
        checks++;
        if (rises !== 3) begin errors++; $display("FAIL continuous strobe count: got %0d expected 3", rises); end
        checks++;
        if (first_hi !== 3) begin errors++; $display("FAIL continuous start latency: got edge %0d expected 3", first_hi); end
        checks++;
        if (last_hi !== 17) begin errors++; $display("FAIL continuous last high: got edge %0d expected 17", last_hi); end
    endtask

    task automatic test_burst();
        logic [31:0] rd;
        int rises;
        for (int e = 0; e < MAXE; e++) en_lvl[e] = (e < 40);
        run_scenario("burst", 2, 4, 52);
        rises = 0;
        for (int e = 0; e < 52; e++) if (act_stb[e]) rises++;
        checks++;
        if (rises !== 4) begin errors++; $display("FAIL burst period count: got %0d expected 4", rises); end
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd[1] !== 1'b1 || rd[31:16] !== 16'd4) begin
            errors++;
            $display("FAIL burst status: got done=%b cycles=%0d expected done=1 cycles=4", rd[1], rd[31:16]);
        end
        clk_enable_in = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++;
            $display("FAIL burst restart status: got 0x%08h expected 0x00000001", rd);
        end
        clk_enable_in = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_half_change();
        int len;
        bus_write(ADDR_HALF, 32'd2);
        bus_write(ADDR_BURST, 32'd0);
        clk_enable_in = 1'b1;
        repeat (3) @(negedge clk);
        // Write lands on the edge during the first HIGH cycle.
        address = ADDR_HALF; writedata = 32'd5; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        $display("WR addr=0 data=0x00000005 (mid-HIGH)");
        checks++;
        if (drive_out !== 1'b1) begin errors++; $display("FAIL half_change start: drive got %b expected 1", drive_out); end
        count_run(1'b1, len);
        checks++;
        if (len !== 2) begin errors++; $display("FAIL half_change current high: got %0d expected 2", len); end
        count_run(1'b0, len);
        checks++;
        if (len !== 5) begin errors++; $display("FAIL half_change next low: got %0d expected 5", len); end
        count_run(1'b1, len);
        checks++;
        if (len !== 5) begin errors++; $display("FAIL half_change next high: got %0d expected 5", len); end
        clk_enable_in = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_done_set_wins();
        logic [31:0] rd;
        int highs;
        bus_write(ADDR_HALF, 32'd2);
        bus_write(ADDR_BURST, 32'd1);
        clk_enable_in = 1'b1;
        repeat (6) @(negedge clk);
        // Clear write coincides with the edge that completes the single-period burst.
        address = ADDR_STATUS; writedata = 32'd2; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        $display("WR addr=2 data=0x00000002 (burst end)");
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h0001_0002) begin
            errors++;
            $display("FAIL done set-wins status: got 0x%08h expected 0x00010002", rd);
        end
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (drive_out) highs++;
        end
        checks++;
        if (highs !== 0) begin errors++; $display("FAIL done hold: got %0d high cycles expected 0", highs); end
        bus_write(ADDR_STATUS, 32'd2);
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd[1] !== 1'b0) begin errors++; $display("FAIL done clear: got %b expected 0", rd[1]); end
        clk_enable_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_random();
        int h;
        int b;
        int pos;
        bit lvl;
        int len;
        for (int it = 0; it < 6; it++) begin
            h = int'($urandom_range(1, 5));
            b = int'($urandom_range(0, 4));
            for (int e = 0; e < MAXE; e++) en_lvl[e] = 1'b0;
            pos = 0;
            lvl = 1'b1;
            for (int seg = 0; seg < 3; seg++) begin
                len = int'($urandom_range(1, 6*h + 4));
                for (int j = 0; j < len; j++) begin
                    en_lvl[pos] = lvl;
                    pos++;
                end
                lvl = !lvl;
            end
            pos += 2*h + 8;
            run_scenario($sformatf("random%0d", it), h, b, pos);
        end
    endtask

    task automatic test_reset_async();
        logic [31:0] rd;
        int w;
        bus_write(ADDR_HALF, 32'd3);
        bus_write(ADDR_BURST, 32'd0);
        clk_enable_in = 1'b1;
        w = 0;
        while (drive_out !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (drive_out !== 1'b1 || sample_strobe !== 1'b1) begin
            errors++;
            $display("FAIL reset_async start: drive=%b strobe=%b after %0d cycles expected 1/1", drive_out, sample_strobe, w);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (drive_out !== 1'b0 || sample_strobe !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_async outputs: got drive=%b strobe=%b run=%b expected 0/0/0",
                     drive_out, sample_strobe, running);
        end
        clk_enable_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(ADDR_HALF, rd);
        checks++;
        if (rd !== 32'd25) begin errors++; $display("FAIL reset_async half_period: got %0d expected 25", rd); end
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_async status: got 0x%08h expected 0", rd); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        clk_enable_in = 1'b0;
        address       = 2'd0;
        chipselect    = 1'b0;
        write_n       = 1'b1;
        writedata     = 32'd0;
        test_reset();
        test_addr3();
        test_continuous();
        test_burst();
        test_half_change();
        test_done_set_wins();
        test_random();
        test_reset_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
